// File: rtl/sevenseg_decoder.sv
// Display-side monitor for the 3-bit segment encoder: synchronises the segment bus,
// waits for a stable pattern, then decodes it into a digit or flags it as blank/illegal.
module sevenseg_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a,
    input  logic                 b,
    input  logic                 c,
    input  logic                 d,
    input  logic                 e,
    input  logic                 f,
    input  logic                 g,
    output logic [2:0]           digit,
    output logic                 digit_valid,
    output logic                 new_digit,
    output logic                 blank,
    output logic                 bad_pattern,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_VALID,
        ST_BAD
    } state_t;

    state_t               state, state_next;
    logic [6:0]           seg_bus;
    logic [6:0]           sync1;
    logic [6:0]           cand;
    logic [CNT_W-1:0]     stab_cnt, stab_cnt_next;
    logic                 accept;
    logic                 legal;
    logic                 is_zero;
    logic [2:0]           decoded;
    logic [2:0]           digit_next;
    logic                 new_digit_next;
    logic [ERR_CNT_W-1:0] err_count_next;

    assign seg_bus = {a, b, c, d, e, f, g};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            cand     <= '0;
            stab_cnt <= '0;
        end else begin
            sync1    <= seg_bus;
            cand     <= sync1;
            stab_cnt <= stab_cnt_next;
        end
    end

    // sync1 is the candidate arriving on this edge, so comparing it with cand tells
    // whether the new candidate matches the one it replaces.
    always_comb begin
        stab_cnt_next = stab_cnt;
        if (sync1 != cand) begin
            stab_cnt_next = '0;
        end else if (stab_cnt != CNT_MAX) begin
            stab_cnt_next = stab_cnt + 1'b1;
        end
        accept = (stab_cnt_next == CNT_MAX) && (stab_cnt != CNT_MAX);
    end

    always_comb begin
        legal   = 1'b1;
        decoded = 3'd0;
        is_zero = (cand == 7'h00);
        case (cand)
            7'h7E:   decoded = 3'd0;
            7'h30:   decoded = 3'd1;
            7'h6D:   decoded = 3'd2;
            7'h79:   decoded = 3'd3;
            7'h33:   decoded = 3'd4;
            7'h5B:   decoded = 3'd5;
            7'h5F:   decoded = 3'd6;
            7'h70:   decoded = 3'd7;
            default: legal   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_BLANK;
            digit     <= 3'd0;
            new_digit <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_next;
            digit     <= digit_next;
            new_digit <= new_digit_next;
            err_count <= err_count_next;
        end
    end

    // Only an accept event moves the FSM; between accepts every output holds.
    always_comb begin
        state_next     = state;
        digit_next     = digit;
        new_digit_next = 1'b0;
        err_count_next = err_count;
        if (accept) begin
            if (is_zero) begin
                state_next = ST_BLANK;
            end else if (legal) begin
                state_next     = ST_VALID;
                digit_next     = decoded;
                new_digit_next = (state != ST_VALID) || (digit != decoded);
            end else begin
                state_next = ST_BAD;
                if (err_count != {ERR_CNT_W{1'b1}}) begin
                    err_count_next = err_count + 1'b1;
                end
            end
        end
    end

    assign digit_valid = (state == ST_VALID);
    assign blank       = (state == ST_BLANK);
    assign bad_pattern = (state == ST_BAD);

endmodule

// File: tb/tb_sevenseg_decoder.sv
// Directed bench for sevenseg_decoder: default instance for latency, decode, glitch,
// illegal-pattern and reset behaviour; a 2-bit err_count instance for saturation.
module tb_sevenseg_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst2_n;
    logic [6:0] bus;
    logic [6:0] bus2;

    logic [2:0] digit, digit2;
    logic       digit_valid, digit_valid2;
    logic       new_digit, new_digit2;
    logic       blank, blank2;
    logic       bad_pattern, bad_pattern2;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;
    int consec      = 0;
    int bad_seen    = 0;
    int one_seen    = 0;
    logic [2:0] pulse_digit = 3'd0;
    logic       prev_new    = 1'b0;

    logic [6:0] codes [8] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70};

    always #5 clk = ~clk;

    sevenseg_decoder #(.STABLE_CYCLES(4), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a(bus[6]), .b(bus[5]), .c(bus[4]), .d(bus[3]), .e(bus[2]), .f(bus[1]), .g(bus[0]),
        .digit(digit), .digit_valid(digit_valid), .new_digit(new_digit),
        .blank(blank), .bad_pattern(bad_pattern), .err_count(err_count)
    );

    sevenseg_decoder #(.STABLE_CYCLES(4), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst2_n),
        .a(bus2[6]), .b(bus2[5]), .c(bus2[4]), .d(bus2[3]), .e(bus2[2]), .f(bus2[1]), .g(bus2[0]),
        .digit(digit2), .digit_valid(digit_valid2), .new_digit(new_digit2),
        .blank(blank2), .bad_pattern(bad_pattern2), .err_count(err_count2)
    );

    // Drives a pattern for a number of cycles, sampling 1 ns after each rising edge and
    // accumulating pulse/bad/glitch statistics for the default instance.
    task automatic applyStimulus(input bit to_dut2, input logic [6:0] pattern, input int cycles);
        if (to_dut2) bus2 = pattern;
        else         bus  = pattern;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (!to_dut2) begin
                if (new_digit) begin
                    pulses++;
                    pulse_digit = digit;
                end
                if (new_digit && prev_new) consec++;
                prev_new = new_digit;
                if (bad_pattern) bad_seen++;
                if (digit == 3'd1) one_seen++;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearStats();
        pulses   = 0;
        consec   = 0;
        bad_seen = 0;
        one_seen = 0;
    endtask

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        bus    = 7'h00;
        bus2   = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset values");
        checkOutput("rst_digit", 32'(digit), 32'd0);
        checkOutput("rst_valid", 32'(digit_valid), 32'd0);
        checkOutput("rst_new", 32'(new_digit), 32'd0);
        checkOutput("rst_blank", 32'(blank), 32'd1);
        checkOutput("rst_bad", 32'(bad_pattern), 32'd0);
        checkOutput("rst_err", 32'(err_count), 32'd0);
        checkOutput("rst2_err", 32'(err_count2), 32'd0);

        $display("[TB] first accept latency");
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        clearStats();
        applyStimulus(1'b0, 7'h6D, 5);
        checkOutput("t1_valid_e5", 32'(digit_valid), 32'd0);
        checkOutput("t1_blank_e5", 32'(blank), 32'd1);
        applyStimulus(1'b0, 7'h6D, 1);
        checkOutput("t1_digit_e6", 32'(digit), 32'd2);
        checkOutput("t1_valid_e6", 32'(digit_valid), 32'd1);
        checkOutput("t1_new_e6", 32'(new_digit), 32'd1);
        checkOutput("t1_blank_e6", 32'(blank), 32'd0);
        applyStimulus(1'b0, 7'h6D, 1);
        checkOutput("t1_new_e7", 32'(new_digit), 32'd0);
        applyStimulus(1'b0, 7'h6D, 5);
        checkOutput("t1_pulses", 32'(pulses), 32'd1);

        $display("[TB] all legal codes");
        clearStats();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, codes[i], 10);
            checkOutput("t2_digit", 32'(digit), 32'(i));
        end
        checkOutput("t2_pulses", 32'(pulses), 32'd8);
        checkOutput("t2_consec", 32'(consec), 32'd0);
        checkOutput("t2_err", 32'(err_count), 32'd0);
        checkOutput("t2_bad_seen", 32'(bad_seen), 32'd0);

        $display("[TB] held illegal pattern");
        applyStimulus(1'b0, 7'h5B, 10);
        checkOutput("t4_digit5", 32'(digit), 32'd5);
        clearStats();
        applyStimulus(1'b0, 7'h4F, 20);
        checkOutput("t4_bad", 32'(bad_pattern), 32'd1);
        checkOutput("t4_valid", 32'(digit_valid), 32'd0);
        checkOutput("t4_blank", 32'(blank), 32'd0);
        checkOutput("t4_digit", 32'(digit), 32'd5);
        checkOutput("t4_err", 32'(err_count), 32'd1);
        checkOutput("t4_pulses", 32'(pulses), 32'd0);
        applyStimulus(1'b0, 7'h5B, 10);
        checkOutput("t4_re_pulses", 32'(pulses), 32'd1);
        checkOutput("t4_re_digit", 32'(digit), 32'd5);
        checkOutput("t4_re_valid", 32'(digit_valid), 32'd1);
        checkOutput("t4_re_bad", 32'(bad_pattern), 32'd0);

        $display("[TB] reset mid-settle");
        applyStimulus(1'b0, 7'h70, 3);
        checkOutput("t6_pre_digit", 32'(digit), 32'd5);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_digit", 32'(digit), 32'd0);
        checkOutput("t6_rst_valid", 32'(digit_valid), 32'd0);
        checkOutput("t6_rst_blank", 32'(blank), 32'd1);
        checkOutput("t6_rst_bad", 32'(bad_pattern), 32'd0);
        checkOutput("t6_rst_new", 32'(new_digit), 32'd0);
        checkOutput("t6_rst_err", 32'(err_count), 32'd0);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 7'h70, 5);
        checkOutput("t6_valid_e5", 32'(digit_valid), 32'd0);
        checkOutput("t6_digit_e5", 32'(digit), 32'd0);
        applyStimulus(1'b0, 7'h70, 1);
        checkOutput("t6_digit_e6", 32'(digit), 32'd7);
        checkOutput("t6_valid_e6", 32'(digit_valid), 32'd1);
        checkOutput("t6_new_e6", 32'(new_digit), 32'd1);
        clearStats();
        applyStimulus(1'b0, 7'h00, 10);
        checkOutput("t6_blank", 32'(blank), 32'd1);
        checkOutput("t6_blank_valid", 32'(digit_valid), 32'd0);
        checkOutput("t6_blank_digit", 32'(digit), 32'd7);
        checkOutput("t6_blank_pulses", 32'(pulses), 32'd0);

        $display("[TB] glitch rejection");
        clearStats();
        applyStimulus(1'b0, 7'h30, 3);
        applyStimulus(1'b0, 7'h7E, 10);
        checkOutput("t3_one_seen", 32'(one_seen), 32'd0);
        checkOutput("t3_pulses", 32'(pulses), 32'd1);
        checkOutput("t3_pulse_digit", 32'(pulse_digit), 32'd0);
        checkOutput("t3_digit", 32'(digit), 32'd0);
        checkOutput("t3_err", 32'(err_count), 32'd0);

        $display("[TB] err_count saturation");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 7'h01, 10);
            checkOutput("t5_err", 32'(err_count2), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
            checkOutput("t5_bad", 32'(bad_pattern2), 32'd1);
            applyStimulus(1'b1, 7'h30, 10);
        end
        checkOutput("t5_err_final", 32'(err_count2), 32'd3);
        checkOutput("t5_digit", 32'(digit2), 32'd1);
        checkOutput("t5_valid", 32'(digit_valid2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
